gpio_in_capture: RTL and testbench
==================================

// Module: gpio_in_capture
// PURPOSE
//  Input-direction companion to the GPIO pin driver bank: samples the external
//  gpio_pins, synchronises and (optionally) debounces them, and presents a clean
//  registered data_out word. Detects per-pin rising/falling edges into a sticky
//  write-1-to-clear status register and raises a level interrupt for the CPU side.
// PARAMETERS
//  N_PINS          16  number of GPIO pins handled
//  SYNC_STAGES     2   synchroniser flops per pin (legal >= 2)
//  DEBOUNCE_CYCLES 4   consecutive differing cycles before data_out follows (legal >= 1)
// PORTS
//  clk         in   1       single clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  gpio_pins   in   N_PINS  asynchronous external pin levels
//  rise_en     in   N_PINS  per-pin rising-edge event enable
//  fall_en     in   N_PINS  per-pin falling-edge event enable
//  irq_en      in   N_PINS  per-pin interrupt mask (1 = contributes to irq)
//  clr_valid   in   1       one-cycle strobe: apply clr_mask
//  clr_mask    in   N_PINS  write-1-to-clear bits for status
//  data_out    out  N_PINS  synchronised/debounced pin levels
//  status      out  N_PINS  sticky edge-event flags
//  irq         out  1       registered OR of (status & irq_en)
// BEHAVIOUR
//  - Reset (sync, active-high): sync chains, debounce counters, data_out, status,
//    irq all 0. Reset has priority over every other input on the same edge.
//  - Sync: gpio_pins[i] -> SYNC_STAGES-flop chain; sync_q[i] = last stage.
//  - Debounce per pin: cnt width $clog2(DEBOUNCE_CYCLES+1).
//    sync_q == data_out -> cnt <= 0.
//    sync_q != data_out and cnt == DEBOUNCE_CYCLES-1 -> data_out <= sync_q, cnt <= 0.
//    otherwise -> cnt <= cnt + 1. Glitch shorter than DEBOUNCE_CYCLES: no change.
//  - Latency: pin change stable before edge 1 -> data_out updates on edge
//    SYNC_STAGES + DEBOUNCE_CYCLES.
//  - Edge events: on the edge data_out[i] goes 0->1 with rise_en[i]=1, or 1->0 with
//    fall_en[i]=1, status[i] <= 1 on that same edge. Enables are sampled that edge.
//  - Clear: clr_valid=1 -> status <= status & ~clr_mask, except bits set by an event
//    that same edge stay 1 (set wins). clr_valid=0 -> clr_mask ignored.
//  - irq <= |(status_next & irq_en) on every edge: asserts the edge status sets,
//    drops the edge clear/mask removes the last contributor. irq_en change seen
//    at next edge.
//  - After reset release, pins held high give data_out 0->1 transitions, hence a
//    rising event if rise_en=1 (intended; software clears after init).
//  - Reset mid-debounce: count discarded, data_out returns 0, restart from scratch.
//  - No FSM beyond per-pin counters; pins fully independent.
// CONFIGURATION
//  GPIO_IN_DEBOUNCE_EN defined: debounce counters as above.
//  GPIO_IN_DEBOUNCE_EN undefined: no counters; data_out <= sync_q every edge
//    (identical to DEBOUNCE_CYCLES=1); latency SYNC_STAGES+1 edges; parameter ignored.
// TESTING  (N_PINS=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
//  1 reset, gpio_pins=0x0001, rise_en=0xFFFF, irq_en=0x0001 -> data_out[0]=1 at edge 6
//    after release; status=0x0001 and irq=1 on same edge.
//  2 pin 3 pulse high for 3 cycles -> data_out and status unchanged; pulse 4+ cycles
//    -> data_out[3]=1 at edge 6 after the change.
//  3 status=0x0009, clr_valid=1, clr_mask=0x0008 -> status=0x0001 next edge; irq
//    stays 1 only if irq_en[0]=1.
//  4 clear of bit 5 on same edge as new rising event on pin 5 -> status[5]=1.
//  5 fall_en=0x0004, rise_en=0, pin 2 0->1->0 -> status=0x0004 only after fall.
//  6 macro undefined: pin 7 1-cycle glitch -> data_out[7] pulses 1 cycle, 3 edges late.

Source files
------------

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: input side of the GPIO bank.
// The module has four stages:
//   - synchronises the asynchronous gpio_pins;
//   - debounces them when GPIO_IN_DEBOUNCE_EN is defined;
//   - registers the clean levels on data_out;
//   - latches enabled rising/falling edges into a sticky, write-1-to-clear status word
//     that drives a level irq.
// Macro GPIO_IN_DEBOUNCE_EN:
//   - undefined (the default build): data_out follows the synchroniser every cycle and
//     DEBOUNCE_CYCLES is not used.
//   - defined: each pin has a counter that must see DEBOUNCE_CYCLES consecutive
//     differing samples before data_out changes.
module gpio_in_capture #(
    parameter int unsigned N_PINS          = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PINS-1:0] gpio_pins,
    input  logic [N_PINS-1:0] rise_en,
    input  logic [N_PINS-1:0] fall_en,
    input  logic [N_PINS-1:0] irq_en,
    input  logic              clr_valid,
    input  logic [N_PINS-1:0] clr_mask,
    output logic [N_PINS-1:0] data_out,
    output logic [N_PINS-1:0] status,
    output logic              irq
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("gpio_in_capture: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [N_PINS-1:0] sync_chain_q [SYNC_STAGES];
    logic [N_PINS-1:0] sync_q;
    logic [N_PINS-1:0] data_q, data_d;
    logic [N_PINS-1:0] status_q, status_d;
    logic              irq_q, irq_d;
    logic [N_PINS-1:0] rise_evt, fall_evt, clr_bits;

    // Metastability chain: one flop stage per SYNC_STAGES, all pins in parallel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_chain_q[s] <= '0;
            end
        end else begin
            sync_chain_q[0] <= gpio_pins;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_chain_q[s] <= sync_chain_q[s-1];
            end
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q [N_PINS];
    logic [CntW-1:0] cnt_d [N_PINS];

    // Per-pin run counter: data_out only follows after an uninterrupted run of differences.
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < int'(N_PINS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == data_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                data_d[i] = sync_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Debounce counter state; reset discards any partially counted run.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N_PINS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_PINS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    // Without debounce the clean level is simply the synchroniser output.
    always_comb begin
        data_d = sync_q;
    end
`endif

    // Edge events, clear and irq next-state; an event set on the same edge beats a clear.
    always_comb begin
        rise_evt = data_d & ~data_q & rise_en;
        fall_evt = ~data_d & data_q & fall_en;
        clr_bits = clr_valid ? clr_mask : '0;
        status_d = (status_q & ~clr_bits) | rise_evt | fall_evt;
        irq_d    = |(status_d & irq_en);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign data_out = data_q;
    assign status   = status_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Bench for gpio_in_capture: directed vectors with literal expectations plus a
// window-based reference model compared on every falling clock edge.
module tb_gpio_in_capture;

    localparam int S = 2;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif
    localparam int HL  = S + D;
    localparam int LAT = S + D;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpio_pins, rise_en, fall_en, irq_en, clr_mask;
    logic        clr_valid;
    logic [15:0] data_out, status;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit running = 1'b1;

    gpio_in_capture #(
        .N_PINS         (16),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .gpio_pins(gpio_pins),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .irq_en   (irq_en),
        .clr_valid(clr_valid),
        .clr_mask (clr_mask),
        .data_out (data_out),
        .status   (status),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model.
    // hist[k] holds the pin sample taken k edges ago. The synchronised level seen at an
    // edge is therefore hist[S]. A pin's clean level flips once its last D synchronised
    // samples all disagree with it.
    logic [15:0] hist [HL];
    logic [15:0] m_dout, m_status, m_next, m_evt;
    logic        m_irq;
    bit          flip;

    task automatic model_step();
        if (reset) begin
            for (int k = 0; k < HL; k++) hist[k] = '0;
            m_dout   = '0;
            m_status = '0;
            m_irq    = 1'b0;
        end else begin
            for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = gpio_pins;
            m_next = m_dout;
            for (int i = 0; i < 16; i++) begin
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (hist[S+j][i] == m_dout[i]) flip = 1'b0;
                end
                if (flip) m_next[i] = ~m_dout[i];
            end
            m_evt    = (m_next & ~m_dout & rise_en) | (~m_next & m_dout & fall_en);
            m_status = (m_status & ~(clr_valid ? clr_mask : 16'h0)) | m_evt;
            m_irq    = |(m_status & irq_en);
            m_dout   = m_next;
        end
    endtask

    always @(posedge clk) model_step();

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (running) begin
            checks++;
            if (data_out !== m_dout || status !== m_status || irq !== m_irq) begin
                errors++;
                $display("FAIL model_cmp t=%0t: dut data=%h status=%h irq=%b, model data=%h status=%h irq=%b",
                         $time, data_out, status, irq, m_dout, m_status, m_irq);
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        gpio_pins = 16'h0001;
        rise_en   = 16'hFFFF;
        fall_en   = 16'h0000;
        irq_en    = 16'h0001;
        clr_valid = 1'b0;
        clr_mask  = 16'h0000;
        step(2);
        chk("reset_data", data_out, 16'h0000);
        chk("reset_status", status, 16'h0000);
        chk("reset_irq", {15'b0, irq}, 16'h0000);

        // Pin 0 high through reset: it appears on data_out LAT edges after release.
        reset = 1'b0;
        step(LAT - 1);
        chk("t1_data_early", data_out, 16'h0000);
        chk("t1_status_early", status, 16'h0000);
        step(1);
        chk("t1_data", data_out, 16'h0001);
        chk("t1_status", status, 16'h0001);
        chk("t1_irq", {15'b0, irq}, 16'h0001);

`ifdef GPIO_IN_DEBOUNCE_EN
        // A 3-cycle pulse on pin 3 is filtered out.
        gpio_pins = 16'h0009;
        step(3);
        gpio_pins = 16'h0001;
        step(8);
        chk("t2_glitch_data", data_out, 16'h0001);
        chk("t2_glitch_status", status, 16'h0001);
`else
        // A 1-cycle glitch on pin 7 passes through, arriving 3 edges late.
        gpio_pins = 16'h0081;
        step(1);
        gpio_pins = 16'h0001;
        step(2);
        chk("t6_glitch_data", data_out, 16'h0081);
        chk("t6_glitch_status", status, 16'h0081);
        step(1);
        chk("t6_glitch_gone", data_out, 16'h0001);
        clr_valid = 1'b1;
        clr_mask  = 16'h0080;
        step(1);
        clr_valid = 1'b0;
        chk("t6_clear", status, 16'h0001);
        step(4);
`endif

        // Pin 3 held high is accepted after LAT edges.
        gpio_pins = 16'h0009;
        step(LAT - 1);
        chk("t2_hold_early", data_out, 16'h0001);
        step(1);
        chk("t2_hold_data", data_out, 16'h0009);
        chk("t2_hold_status", status, 16'h0009);

        // Clear bit 3 and check how irq_en shapes irq.
        clr_valid = 1'b1;
        clr_mask  = 16'h0008;
        step(1);
        clr_valid = 1'b0;
        chk("t3_status", status, 16'h0001);
        chk("t3_irq", {15'b0, irq}, 16'h0001);
        irq_en = 16'h0008;
        step(1);
        chk("t3_irq_masked", {15'b0, irq}, 16'h0000);
        irq_en = 16'h0001;
        step(1);
        chk("t3_irq_unmasked", {15'b0, irq}, 16'h0001);

        // A clear of bits 0 and 5 lands on the same edge as pin 5's rising event.
        gpio_pins = 16'h0029;
        step(LAT - 1);
        clr_valid = 1'b1;
        clr_mask  = 16'h0021;
        step(1);
        clr_valid = 1'b0;
        chk("t4_set_wins", status, 16'h0020);
        chk("t4_irq", {15'b0, irq}, 16'h0000);

        // Only the falling edge of pin 2 sets status.
        clr_valid = 1'b1;
        clr_mask  = 16'hFFFF;
        rise_en   = 16'h0000;
        fall_en   = 16'h0004;
        step(1);
        clr_valid = 1'b0;
        chk("t5_cleared", status, 16'h0000);
        gpio_pins = 16'h002D;
        step(LAT + 2);
        chk("t5_rise_data", data_out, 16'h002D);
        chk("t5_rise_status", status, 16'h0000);
        gpio_pins = 16'h0029;
        step(LAT);
        chk("t5_fall_data", data_out, 16'h0029);
        chk("t5_fall_status", status, 16'h0004);
        irq_en = 16'h0004;
        step(1);
        chk("t5_irq", {15'b0, irq}, 16'h0001);

        // Reset in the middle of a pending change throws it away and starts over.
        gpio_pins = 16'hFFFF;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_mid_data", data_out, 16'h0000);
        chk("rst_mid_status", status, 16'h0000);
        step(LAT - 1);
        chk("rst_restart_early", data_out, 16'h0000);
        step(1);
        chk("rst_restart_data", data_out, 16'hFFFF);
        chk("rst_restart_status", status, 16'h0000);

        step(2);
        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
